// File: rtl/redux_pkg.sv
// redux_pkg: shared definitions for the Redux-V multicycle core.
//   - opcode values (ir[7:4])
//   - FSM state encoding
//   - ALU select codes used between redux_mc and redux_alu
package redux_pkg;

  localparam logic [3:0] OP_BRZR = 4'h0;
  localparam logic [3:0] OP_BRZI = 4'h1;
  localparam logic [3:0] OP_JR   = 4'h2;
  localparam logic [3:0] OP_JI   = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_ORI  = 4'h7;
  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_AND  = 4'hA;
  localparam logic [3:0] OP_OR   = 4'hB;
  localparam logic [3:0] OP_XOR  = 4'hC;
  localparam logic [3:0] OP_NOT  = 4'hD;
  localparam logic [3:0] OP_SHL  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6
  } alu_sel_e;

endpackage

// File: rtl/redux_alu.sv
// redux_alu: combinational ALU for the Redux-V core.
//   a, b : operands (DATA_W)
//   sel  : operation select (alu_sel_e)
//   s    : result, wraps modulo 2^DATA_W, no flags
module redux_alu
  import redux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_sel_e          sel,
  output logic [DATA_W-1:0] s
);

  localparam int SH_W = $clog2(DATA_W);

  always_comb begin
    s = '0;
    case (sel)
      ALU_ADD: s = a + b;
      ALU_SUB: s = a - b;
      ALU_AND: s = a & b;
      ALU_OR:  s = a | b;
      ALU_XOR: s = a ^ b;
      ALU_NOT: s = ~b;
      // only the low log2(DATA_W) bits of the shift amount count
      ALU_SHL: s = a << b[SH_W-1:0];
      default: s = '0;
    endcase
  end

endmodule

// File: rtl/redux_mc.sv
// redux_mc: multicycle Redux-V core, FETCH -> EXEC -> (MEM) -> FETCH, plus HALT.
//   clk, rst                    : clock, async active-high reset
//   imem_req/addr/ack/rdata     : instruction fetch port (8-bit words)
//   dmem_req/we/addr/wdata/ack/rdata : data port, DATA_W wide
//   halted                      : core sits in HALT
//   retire                      : one-cycle pulse in the final cycle of each instruction
module redux_mc
  import redux_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted,
  output logic              retire
);

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       pc_q, pc_d;
  logic [7:0]              ir_q, ir_d;
  logic [3:0][DATA_W-1:0]  rf_q;

  logic                    rf_we;
  logic [1:0]              rf_idx;
  logic [DATA_W-1:0]       rf_wdata;

  logic [3:0]              op;
  logic [1:0]              ra, rb;
  logic [3:0]              imm;
  logic [DATA_W-1:0]       ra_val, rb_val, r0_val;
  logic [DATA_W-1:0]       imm_sx, imm_zx, pc_inc, pc_rel;

  logic [DATA_W-1:0]       alu_a, alu_b, alu_s;
  alu_sel_e                alu_sel;

  assign op     = ir_q[7:4];
  assign ra     = ir_q[3:2];
  assign rb     = ir_q[1:0];
  assign imm    = ir_q[3:0];
  assign ra_val = rf_q[ra];
  assign rb_val = rf_q[rb];
  assign r0_val = rf_q[0];
  assign imm_sx = {{(DATA_W-4){imm[3]}}, imm};
  assign imm_zx = DATA_W'(imm);
  assign pc_inc = pc_q + DATA_W'(1);
  assign pc_rel = pc_q + imm_sx;

  // addi/ori are hardwired to R0 with an immediate; all other ALU ops are R[ra] op R[rb]
  always_comb begin
    alu_a   = ra_val;
    alu_b   = rb_val;
    alu_sel = ALU_ADD;
    case (op)
      OP_ADDI: begin alu_a = r0_val; alu_b = imm_sx; end
      OP_ORI:  begin alu_a = r0_val; alu_b = imm_zx; alu_sel = ALU_OR; end
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      OP_OR:   alu_sel = ALU_OR;
      OP_XOR:  alu_sel = ALU_XOR;
      OP_NOT:  alu_sel = ALU_NOT;
      OP_SHL:  alu_sel = ALU_SHL;
      default: alu_sel = ALU_ADD;
    endcase
  end

  redux_alu #(.DATA_W(DATA_W)) u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .sel (alu_sel),
    .s   (alu_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      rf_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      if (rf_we) rf_q[rf_idx] <= rf_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    rf_we      = 1'b0;
    rf_idx     = ra;
    rf_wdata   = alu_s;
    imem_req   = 1'b0;
    imem_addr  = pc_q;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    halted     = 1'b0;
    retire     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // common case: retire now and fall through to pc+1
        state_d = ST_FETCH;
        retire  = 1'b1;
        pc_d    = pc_inc;
        case (op)
          OP_BRZR: if (ra_val == '0) pc_d = rb_val;
          OP_BRZI: if (r0_val == '0) pc_d = pc_rel;
          OP_JR:   pc_d = rb_val;
          OP_JI:   pc_d = pc_rel;
          OP_LD, OP_ST: begin
            state_d = ST_MEM;
            retire  = 1'b0;
            pc_d    = pc_q;
          end
          OP_HALT: begin
            state_d = ST_HALT;
            retire  = 1'b0;
            pc_d    = pc_q;
          end
          default: begin
            rf_we = 1'b1;
            if (op == OP_ADDI || op == OP_ORI) rf_idx = 2'd0;
          end
        endcase
      end
      ST_MEM: begin
        // registers are frozen while waiting, so addr/wdata stay stable
        dmem_req   = 1'b1;
        dmem_we    = (op == OP_ST);
        dmem_addr  = rb_val;
        dmem_wdata = ra_val;
        if (dmem_ack) begin
          if (op == OP_LD) begin
            rf_we    = 1'b1;
            rf_wdata = dmem_rdata;
          end
          pc_d    = pc_inc;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase
    // state already reads FETCH during reset; keep every output quiet until release
    if (rst) begin
      imem_req   = 1'b0;
      imem_addr  = '0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      halted     = 1'b0;
      retire     = 1'b0;
    end
  end

endmodule

// File: tb/tb_redux_mc.sv
// tb_redux_mc: directed bench for redux_mc. dut_a is DATA_W=8, dut_b is DATA_W=16.
// Memories are bench arrays answered on the falling edge with programmable wait states.
module tb_redux_mc;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;

  logic        a_imem_req, a_dmem_req, a_dmem_we, a_halted, a_retire;
  logic [7:0]  a_imem_addr, a_dmem_addr, a_dmem_wdata;
  logic        a_imem_ack = 1'b0, a_dmem_ack = 1'b0;
  logic [7:0]  a_imem_rdata = 8'h00, a_dmem_rdata = 8'h00;

  logic        b_imem_req, b_dmem_req, b_dmem_we, b_halted, b_retire;
  logic [15:0] b_imem_addr, b_dmem_addr, b_dmem_wdata;
  logic        b_imem_ack = 1'b0, b_dmem_ack = 1'b0;
  logic [7:0]  b_imem_rdata = 8'h00;
  logic [15:0] b_dmem_rdata = 16'h0000;

  logic [7:0]  prog_a [256];
  logic [7:0]  prog_b [256];
  int          iw_a = 0, dw_a = 0, ic_a = 0, dc_a = 0;
  int          dw_b = 0, ic_b = 0, dc_b = 0;
  logic [15:0] drd_b = 16'h0000;

  int checks = 0, errors = 0;

  redux_mc #(.DATA_W(8)) dut_a (
    .clk(clk), .rst(rst_a),
    .imem_req(a_imem_req), .imem_addr(a_imem_addr), .imem_ack(a_imem_ack), .imem_rdata(a_imem_rdata),
    .dmem_req(a_dmem_req), .dmem_we(a_dmem_we), .dmem_addr(a_dmem_addr), .dmem_wdata(a_dmem_wdata),
    .dmem_ack(a_dmem_ack), .dmem_rdata(a_dmem_rdata), .halted(a_halted), .retire(a_retire)
  );

  redux_mc #(.DATA_W(16)) dut_b (
    .clk(clk), .rst(rst_b),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_ack(b_imem_ack), .imem_rdata(b_imem_rdata),
    .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr), .dmem_wdata(b_dmem_wdata),
    .dmem_ack(b_dmem_ack), .dmem_rdata(b_dmem_rdata), .halted(b_halted), .retire(b_retire)
  );

  initial forever #5 clk = ~clk;

  // memory responders: ack after N full req cycles (N=0 -> zero-wait)
  always @(negedge clk) begin
    if (a_imem_req) begin
      a_imem_ack   = (ic_a == iw_a);
      a_imem_rdata = prog_a[a_imem_addr];
      ic_a         = a_imem_ack ? 0 : ic_a + 1;
    end else begin
      a_imem_ack = 1'b0;
      ic_a       = 0;
    end
    if (a_dmem_req) begin
      a_dmem_ack = (dc_a == dw_a);
      dc_a       = a_dmem_ack ? 0 : dc_a + 1;
    end else begin
      a_dmem_ack = 1'b0;
      dc_a       = 0;
    end
    if (b_imem_req) begin
      b_imem_ack   = (ic_b == 0);
      b_imem_rdata = prog_b[b_imem_addr[7:0]];
      ic_b         = 0;
    end else begin
      b_imem_ack = 1'b0;
    end
    if (b_dmem_req) begin
      b_dmem_ack   = (dc_b == dw_b);
      b_dmem_rdata = drd_b;
      dc_b         = b_dmem_ack ? 0 : dc_b + 1;
    end else begin
      b_dmem_ack = 1'b0;
      dc_b       = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic fill_a();
    for (int i = 0; i < 256; i++) prog_a[i] = 8'hF0;
  endtask

  task automatic rel_a();
    @(posedge clk); #1; rst_a = 1'b0; #1;
  endtask

  // run until retire is seen; c = sample count including the retire cycle
  task automatic run_a(input string tag, output int c);
    c = 0;
    do begin step(); c++; end while (!a_retire && c < 40);
    if (!a_retire) chk({tag, "_timeout"}, 32'(a_retire), 32'd1);
  endtask

  task automatic run_b(input string tag, output int c);
    c = 0;
    do begin step(); c++; end while (!b_retire && c < 40);
    if (!b_retire) chk({tag, "_timeout"}, 32'(b_retire), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int bad;
    logic [7:0] alu_prog [19];
    logic [7:0] st_exp [6];

    // ---- zero-wait ALU run + reset state ----
    fill_a();
    prog_a[0] = 8'h63; prog_a[1] = 8'h6F; prog_a[2] = 8'h54;
    prog_a[3] = 8'h84; prog_a[4] = 8'h54;
    step();
    chk("rst_imem_req", 32'(a_imem_req), 0);
    chk("rst_imem_addr", 32'(a_imem_addr), 0);
    chk("rst_dmem_req", 32'(a_dmem_req), 0);
    chk("rst_halted", 32'(a_halted), 0);
    chk("rst_retire", 32'(a_retire), 0);
    rel_a();
    run_a("t1_63", c); chk("t1_63_cyc", c, 2);
    run_a("t1_6f", c); chk("t1_6f_cyc", c, 2);
    run_a("t1_st", c); chk("t1_st_cyc", c, 3);
    chk("t1_st_we", 32'(a_dmem_we), 1);
    chk("t1_st_addr", 32'(a_dmem_addr), 32'h02);
    chk("t1_st_wdata", 32'(a_dmem_wdata), 32'h00);
    run_a("t1_84", c); chk("t1_84_cyc", c, 2);
    run_a("t1_st2", c);
    chk("t1_st2_wdata", 32'(a_dmem_wdata), 32'h02);

    // ---- fetch wait states ----
    rst_a = 1'b1; iw_a = 3; fill_a(); prog_a[0] = 8'h63;
    step(); rel_a();
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t2_req%0d", i), 32'(a_imem_req), 1);
      chk($sformatf("t2_addr%0d", i), 32'(a_imem_addr), 0);
      chk($sformatf("t2_ret%0d", i), 32'(a_retire), 0);
    end
    step(); chk("t2_retire", 32'(a_retire), 1);
    step(); chk("t2_next_addr", 32'(a_imem_addr), 1);
    iw_a = 0;

    // ---- ALU op sweep, stores expose results; then brzr/jr ----
    alu_prog = '{8'h65, 8'h84, 8'h63, 8'h94, 8'h54, 8'hC4, 8'h54, 8'hB4, 8'h54,
                 8'hA4, 8'h54, 8'hD4, 8'h54, 8'h71, 8'hE4, 8'h54, 8'h04, 8'h09, 8'h00};
    st_exp   = '{8'hFD, 8'hF5, 8'hFD, 8'h08, 8'hF7, 8'hEE};
    rst_a = 1'b1; fill_a();
    for (int i = 0; i < 18; i++) prog_a[i] = alu_prog[i];
    prog_a[8'hEE] = 8'h20;
    step(); rel_a();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      run_a("t3_alu", c);
      if (alu_prog[i] == 8'h54) begin
        chk($sformatf("t3_st%0d_wdata", bad), 32'(a_dmem_wdata), 32'(st_exp[bad]));
        bad++;
      end
    end
    run_a("t3_brzr_nt", c); step(); chk("t3_brzr_nt_addr", 32'(a_imem_addr), 32'h11);
    run_a("t3_brzr_t", c);  step(); chk("t3_brzr_t_addr", 32'(a_imem_addr), 32'hEE);
    run_a("t3_jr", c);      step(); chk("t3_jr_addr", 32'(a_imem_addr), 32'h09);

    // ---- branches ----
    rst_a = 1'b1; fill_a();
    for (int i = 0; i < 5; i++) prog_a[i] = 8'h70;
    prog_a[5] = 8'h1E;
    step(); rel_a();
    for (int i = 0; i < 6; i++) run_a("t4_run", c);
    step(); chk("t4_brzi_taken", 32'(a_imem_addr), 32'h03);

    rst_a = 1'b1; fill_a(); prog_a[0] = 8'h3F; prog_a[8'hFF] = 8'h70;
    step(); rel_a();
    run_a("t4_ji", c); step(); chk("t4_ji_wrap", 32'(a_imem_addr), 32'hFF);
    run_a("t4_ff", c); step(); chk("t4_pc_wrap", 32'(a_imem_addr), 32'h00);

    rst_a = 1'b1; fill_a(); prog_a[0] = 8'h71; prog_a[1] = 8'h1E;
    step(); rel_a();
    run_a("t4_ori", c); run_a("t4_brzi_nt", c);
    step(); chk("t4_brzi_not", 32'(a_imem_addr), 32'h02);

    // ---- reset mid-MEM ----
    rst_a = 1'b1; fill_a(); prog_a[0] = 8'h63; prog_a[1] = 8'h54; dw_a = 5;
    step(); rel_a();
    run_a("t5_63", c);
    step(); step(); step();
    chk("t5_in_mem_req", 32'(a_dmem_req), 1);
    chk("t5_in_mem_ack", 32'(a_dmem_ack), 0);
    rst_a = 1'b1; #1;
    chk("t5_rst_dmem_req", 32'(a_dmem_req), 0);
    chk("t5_rst_imem_req", 32'(a_imem_req), 0);
    chk("t5_rst_retire", 32'(a_retire), 0);
    dw_a = 0; fill_a(); prog_a[0] = 8'h54;
    step(); rel_a();
    chk("t5_restart_req", 32'(a_imem_req), 1);
    chk("t5_restart_pc", 32'(a_imem_addr), 0);
    run_a("t5_st", c);
    chk("t5_st_cyc", c, 3);
    chk("t5_r0_cleared", 32'(a_dmem_addr), 0);
    chk("t5_r1_cleared", 32'(a_dmem_wdata), 0);

    // ---- halt ----
    rst_a = 1'b1; fill_a();
    step(); rel_a();
    step(); chk("t6_fetch_halted", 32'(a_halted), 0);
    step(); chk("t6_exec_halted", 32'(a_halted), 0);
    chk("t6_exec_retire", 32'(a_retire), 0);
    step(); chk("t6_halted", 32'(a_halted), 1);
    chk("t6_imem_req", 32'(a_imem_req), 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (a_imem_req || a_retire || a_dmem_req || !a_halted) bad++;
    end
    chk("t6_halt_hold", bad, 0);
    rst_a = 1'b1; #1;
    chk("t6_rst_clears", 32'(a_halted), 0);

    // ---- DATA_W=16 load/store with 2 data wait states ----
    for (int i = 0; i < 256; i++) prog_b[i] = 8'hF0;
    prog_b[0] = 8'h44; prog_b[1] = 8'h4C; prog_b[2] = 8'h5D;
    prog_b[3] = 8'h49; prog_b[4] = 8'h58;
    dw_b = 2;
    @(posedge clk); #1; rst_b = 1'b0; #1;
    drd_b = 16'h1234; run_b("t7_ld1", c); chk("t7_ld_cyc", c, 5);
    chk("t7_ld_we", 32'(b_dmem_we), 0);
    drd_b = 16'hBEEF; run_b("t7_ld3", c);
    drd_b = 16'h0000; run_b("t7_st", c);
    chk("t7_st_we", 32'(b_dmem_we), 1);
    chk("t7_st_addr", 32'(b_dmem_addr), 32'h1234);
    chk("t7_st_wdata", 32'(b_dmem_wdata), 32'hBEEF);
    drd_b = 16'hBEEF; run_b("t7_ld2", c);
    chk("t7_ld2_we", 32'(b_dmem_we), 0);
    chk("t7_ld2_addr", 32'(b_dmem_addr), 32'h1234);
    drd_b = 16'h0000; run_b("t7_st2", c);
    chk("t7_st2_we", 32'(b_dmem_we), 1);
    chk("t7_st2_addr", 32'(b_dmem_addr), 32'h0000);
    chk("t7_r2_wdata", 32'(b_dmem_wdata), 32'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
